// File: rtl/pc_fetch_gen_pkg.sv
// Shared PC-mux select codes, fetch FSM encodings and a redirect qualifier.
package pc_fetch_gen_pkg;

    typedef enum logic [1:0] {
        PC_MUX_SEQ      = 2'd0,
        PC_MUX_ALU_OUT  = 2'd1,
        PC_MUX_PC_ADDER = 2'd2,
        PC_MUX_TRAP     = 2'd3
    } pc_mux_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PEND  = 2'd2
    } fetch_state_e;

    // A SEQ select carries no target, so it never counts as a redirect.
    function automatic logic is_redirect(input logic vld, input pc_mux_e s);
        return vld && (s != PC_MUX_SEQ);
    endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Fetch request bus between the PC generator (master) and instruction memory (slave).
interface pc_fetch_gen_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            req_epoch;

    modport master (
        output req_valid,
        output req_addr,
        output req_epoch,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_epoch,
        output req_ready
    );
endinterface

// File: rtl/pc_target_mux.sv
// Redirect target select + alignment; PC_MISALIGN_TRAP_EN keeps raw target and flags misalignment.
// Latency: combinational. Backpressure: none.
module pc_target_mux
    import pc_fetch_gen_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  pc_mux_e         sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_adder_result,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw = TRAP_VEC;
        case (sel)
            PC_MUX_ALU_OUT:  raw = alu_result;
            PC_MUX_PC_ADDER: raw = pc_adder_result;
            default:         raw = TRAP_VEC;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign target   = raw;
    assign misalign = |raw[1:0];
`else
    assign target   = raw & ~XLEN'(3);
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: BOOT/FETCH/PEND FSM, valid/ready imem request, redirects, epoch tag.
// Latency: redirect visible on req_addr the cycle after it is applied. Optional: PC_MISALIGN_TRAP_EN.
// Backpressure: a shown request holds addr/valid until req_ready; redirects meanwhile park in pend_q.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              INC       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            redirect_valid,
    input  pc_mux_e         sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_adder_result,
    pc_fetch_gen_if.master  req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign,
    output logic [XLEN-1:0] badaddr
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_mis_q, pend_mis_d;
    logic            epoch_q, epoch_d;
    logic            shown_q, shown_d;
    logic            req_vld;
    logic            redir;
    logic            apply;
    logic [XLEN-1:0] apply_tgt;
    logic            apply_mis;
    logic [XLEN-1:0] tgt;
    logic            tgt_mis;

    pc_target_mux #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_target_mux (
        .sel             (sel),
        .alu_result      (alu_result),
        .pc_adder_result (pc_adder_result),
        .target          (tgt),
        .misalign        (tgt_mis)
    );

    assign pc_next = pc_q + XLEN'(INC);
    assign redir   = is_redirect(redirect_valid, sel);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_mis_d = pend_mis_q;
        epoch_d    = epoch_q;
        shown_d    = 1'b0;
        req_vld    = 1'b0;
        apply      = 1'b0;
        apply_tgt  = tgt;
        apply_mis  = tgt_mis;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                req_vld = en | shown_q;
                shown_d = req_vld & ~req.req_ready;
                if (redir && req_vld && !req.req_ready) begin
                    // Cannot retarget a shown request; park the redirect.
                    pend_d     = tgt;
                    pend_mis_d = tgt_mis;
                    state_d    = ST_PEND;
                end else if (redir) begin
                    apply = 1'b1;
                end else if (req_vld && req.req_ready && en) begin
                    pc_d = pc_next;
                end
            end
            ST_PEND: begin
                req_vld = 1'b1;
                if (redir) begin
                    pend_d     = tgt;
                    pend_mis_d = tgt_mis;
                end
                if (req.req_ready) begin
                    apply     = 1'b1;
                    apply_tgt = redir ? tgt : pend_q;
                    apply_mis = redir ? tgt_mis : pend_mis_q;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        if (apply) begin
            pc_d    = apply_mis ? TRAP_VEC : apply_tgt;
            epoch_d = ~epoch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            pend_q     <= '0;
            pend_mis_q <= 1'b0;
            epoch_q    <= 1'b0;
            shown_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_mis_q <= pend_mis_d;
            epoch_q    <= epoch_d;
            shown_q    <= shown_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q;
    logic [XLEN-1:0] badaddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
        end else begin
            misalign_q <= apply & apply_mis;
            if (apply && apply_mis) badaddr_q <= apply_tgt;
        end
    end

    assign misalign = misalign_q;
    assign badaddr  = badaddr_q;
`else
    assign misalign = 1'b0;
    assign badaddr  = '0;
`endif

    assign req.req_valid = req_vld;
    assign req.req_addr  = pc_q;
    assign req.req_epoch = epoch_q;
    assign pc            = pc_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen: scoreboard of accepted {epoch, addr} plus direct state checks.
module tb_pc_fetch_gen;
    import pc_fetch_gen_pkg::*;

    localparam int          XLEN     = 32;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, en, redirect_valid;
    pc_mux_e     sel;
    logic [31:0] alu_result, pc_adder_result;
    logic [31:0] pc, pc_next, badaddr;
    logic        misalign;

    logic        en_w, redirect_valid_w;
    pc_mux_e     sel_w;
    logic [31:0] zero_w;
    logic [31:0] pc_w, pc_next_w, badaddr_w;
    logic        misalign_w;

    int n_chk  = 0;
    int n_fail = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    pc_fetch_gen_if #(.XLEN(XLEN)) bus   ();
    pc_fetch_gen_if #(.XLEN(XLEN)) bus_w ();

    pc_fetch_gen #(.XLEN(XLEN), .RESET_VEC(32'h0), .TRAP_VEC(TRAP_VEC), .INC(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .redirect_valid(redirect_valid), .sel(sel),
        .alu_result(alu_result), .pc_adder_result(pc_adder_result), .req(bus.master),
        .pc(pc), .pc_next(pc_next), .misalign(misalign), .badaddr(badaddr)
    );

    pc_fetch_gen #(.XLEN(XLEN), .RESET_VEC(32'hFFFF_FFFC), .TRAP_VEC(TRAP_VEC), .INC(4)) u_dut_wrap (
        .clk(clk), .rst(rst), .en(en_w), .redirect_valid(redirect_valid_w), .sel(sel_w),
        .alu_result(zero_w), .pc_adder_result(zero_w), .req(bus_w.master),
        .pc(pc_w), .pc_next(pc_next_w), .misalign(misalign_w), .badaddr(badaddr_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ep, input logic [31:0] addr);
        sb.push_back({ep, addr});
    endtask

    // Every accepted request must match the next expected {epoch, addr}.
    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("sb_req", 64'({bus.req_epoch, bus.req_addr}), 64'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_tgt;
        logic        exp_mis;
        logic [31:0] exp_bad;
`ifdef PC_MISALIGN_TRAP_EN
        exp_tgt = TRAP_VEC; exp_mis = 1'b1;
`else
        exp_tgt = 32'h40;   exp_mis = 1'b0;
`endif
        rst = 1'b1; en = 1'b1; redirect_valid = 1'b0; sel = PC_MUX_SEQ;
        alu_result = '0; pc_adder_result = '0; bus.req_ready = 1'b1;
        en_w = 1'b1; redirect_valid_w = 1'b0; sel_w = PC_MUX_SEQ; zero_w = '0;
        bus_w.req_ready = 1'b1;
        tick(); tick();

        check("rst_vld", 64'(bus.req_valid), 64'd0);
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_pc_next", 64'(pc_next), 64'h4);
        check("rst_epoch", 64'(bus.req_epoch), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_badaddr", 64'(badaddr), 64'h0);
        check("wrap_rst_pc_next", 64'(pc_next_w), 64'h0);

        // Sequential fetch after the BOOT cycle
        rst = 1'b0;
        check("boot_vld", 64'(bus.req_valid), 64'd0);
        push(1'b0, 32'h0); push(1'b0, 32'h4);
        tick();
        check("wrap_pc", 64'(pc_w), 64'hFFFF_FFFC);
        tick();
        check("wrap_pc_after", 64'(pc_w), 64'h0);
        check("wrap_pc_next_after", 64'(pc_next_w), 64'h4);
        tick();
        check("seq_addr8", 64'(bus.req_addr), 64'h8);

        // Shown request held under backpressure, en dropped
        bus.req_ready = 1'b0;
        tick();
        en = 1'b0;
        check("hold_vld", 64'(bus.req_valid), 64'd1);
        tick();
        check("hold_addr", 64'(bus.req_addr), 64'h8);
        bus.req_ready = 1'b1; push(1'b0, 32'h8);
        tick();
        check("en0_vld_drop", 64'(bus.req_valid), 64'd0);
        check("en0_pc_hold", 64'(pc), 64'h8);

        // Redirect while stalled -> PEND
        en = 1'b1; push(1'b0, 32'h8);
        tick();
        bus.req_ready = 1'b0; redirect_valid = 1'b1; sel = PC_MUX_ALU_OUT; alu_result = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("pend_addr", 64'(bus.req_addr), 64'hC);
        tick();
        check("pend_vld", 64'(bus.req_valid), 64'd1);
        bus.req_ready = 1'b1; push(1'b0, 32'hC);
        tick();
        check("redir_addr", 64'(bus.req_addr), 64'h40);
        check("redir_epoch", 64'(bus.req_epoch), 64'd1);
        push(1'b1, 32'h40);
        tick();

        // Latest redirect in PEND wins, single epoch toggle
        bus.req_ready = 1'b0; redirect_valid = 1'b1; sel = PC_MUX_PC_ADDER; pc_adder_result = 32'h80;
        tick();
        sel = PC_MUX_TRAP;
        tick();
        redirect_valid = 1'b0;
        check("pend2_addr", 64'(bus.req_addr), 64'h44);
        bus.req_ready = 1'b1; push(1'b1, 32'h44);
        tick();
        check("trap_addr", 64'(bus.req_addr), 64'(TRAP_VEC));
        check("trap_epoch", 64'(bus.req_epoch), 64'd0);
        push(1'b0, TRAP_VEC);
        tick();

        // Misaligned target, applied directly
        redirect_valid = 1'b1; sel = PC_MUX_ALU_OUT; alu_result = 32'h42; push(1'b0, 32'h104);
        tick();
        redirect_valid = 1'b0;
        exp_bad = exp_mis ? 32'h42 : 32'h0;
        check("mis_addr", 64'(bus.req_addr), 64'(exp_tgt));
        check("mis_pulse", 64'(misalign), 64'(exp_mis));
        check("mis_badaddr", 64'(badaddr), 64'(exp_bad));
        push(1'b1, exp_tgt);
        tick();
        check("mis_pulse_end", 64'(misalign), 64'd0);

        // Misaligned target applied from pend_q
        bus.req_ready = 1'b0; redirect_valid = 1'b1; alu_result = 32'h43;
        tick();
        redirect_valid = 1'b0; bus.req_ready = 1'b1; push(1'b1, exp_tgt + 32'h4);
        tick();
        exp_bad = exp_mis ? 32'h43 : 32'h0;
        check("mis_pend_addr", 64'(bus.req_addr), 64'(exp_tgt));
        check("mis_pend_epoch", 64'(bus.req_epoch), 64'd0);
        check("mis_pend_pulse", 64'(misalign), 64'(exp_mis));
        check("mis_pend_badaddr", 64'(badaddr), 64'(exp_bad));

        // Reset in PEND
        bus.req_ready = 1'b0; redirect_valid = 1'b1; alu_result = 32'h200;
        tick();
        redirect_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("pend_rst_pc", 64'(pc), 64'h0);
        check("pend_rst_vld", 64'(bus.req_valid), 64'd0);
        check("pend_rst_epoch", 64'(bus.req_epoch), 64'd0);
        tick(); tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
